// File: rtl/gene_timer_if.sv
// Generation request handshake between gene_timer (master) and the spawner (slave).
interface gene_timer_if;
  localparam int unsigned LANE_W = 2;

  logic              gene_req;
  logic [LANE_W-1:0] gene_lane;
  logic              gene_ack;

  modport master (output gene_req, output gene_lane, input gene_ack);
  modport slave  (input gene_req, input gene_lane, output gene_ack);
endinterface

// File: rtl/gene_timer.sv
// gene_timer: turns the gene_time period into periodic block-generation
// requests with a lane, handshaken req/ack, plus a saturating overrun count.
// Optional feature macro GENE_LFSR_EN: lanes come from an 8-bit Fibonacci
// LFSR (x^8+x^6+x^5+x^4+1) seeded with LFSR_SEED; otherwise round-robin 0..3.
module gene_timer #(
  parameter int unsigned OVR_W     = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_pause,
  input  logic [31:0]      i_gene_time,
  gene_timer_if.master     gif,
  output logic [OVR_W-1:0] o_overrun
);
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned SRC_W      = 8;
  localparam logic [CNT_W-1:0] PERIOD_RST = 32'h0003_0D3F;

`ifdef GENE_LFSR_EN
  localparam logic [SRC_W-1:0] SRC_RST = LFSR_SEED;
`else
  // Round-robin starts at lane 0; upper seed bits ride along and never affect lane order.
  localparam logic [SRC_W-1:0] SRC_RST = {LFSR_SEED[7:2], 2'b00};
`endif

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_q;
  logic [SRC_W-1:0] r_lane_src;
  logic             r_req;
  logic [1:0]       r_lane;
  logic [OVR_W-1:0] r_overrun;

  logic             w_expiry;
  logic             w_issue;
  logic             w_lost;
  logic             w_retire;
  logic [SRC_W-1:0] w_src_next;
  logic [1:0]       w_lane_new;

  assign w_expiry = i_en && !i_pause && (r_cnt == r_period_q);
  assign w_issue  = w_expiry && (!r_req || gif.gene_ack);
  assign w_lost   = w_expiry && r_req && !gif.gene_ack;
  assign w_retire = !w_expiry && r_req && gif.gene_ack;

  // Next lane source and the lane a new request would carry.
  always_comb begin
    w_src_next = r_lane_src;
    w_lane_new = r_lane_src[1:0];
`ifdef GENE_LFSR_EN
    w_src_next = {r_lane_src[6:0],
                  r_lane_src[7] ^ r_lane_src[5] ^ r_lane_src[4] ^ r_lane_src[3]};
    w_lane_new = w_src_next[1:0];
`else
    w_src_next = {r_lane_src[7:2], r_lane_src[1:0] + 2'd1};
    w_lane_new = r_lane_src[1:0];
`endif
  end

  // Period counter; the period is re-latched only while idle or at expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_period_q <= PERIOD_RST;
    end else if (!i_en) begin
      r_cnt      <= '0;
      r_period_q <= i_gene_time;
    end else if (!i_pause) begin
      if (r_cnt == r_period_q) begin
        r_cnt      <= '0;
        r_period_q <= i_gene_time;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Request/ack handshake and lane selection; at most one request outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_lane     <= '0;
      r_lane_src <= SRC_RST;
    end else if (!i_en) begin
      r_req <= 1'b0;
    end else if (w_issue) begin
      r_req      <= 1'b1;
      r_lane     <= w_lane_new;
      r_lane_src <= w_src_next;
    end else if (w_retire) begin
      r_req <= 1'b0;
    end
  end

  // Saturating count of expiries lost to a still-pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else if (w_lost && (r_overrun != {OVR_W{1'b1}})) begin
      r_overrun <= r_overrun + OVR_W'(1);
    end
  end

  assign gif.gene_req  = r_req;
  assign gif.gene_lane = r_lane;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_gene_timer.sv
// Directed self-checking bench for gene_timer; a second instance with a
// 2-bit overrun counter shares the stimulus to exercise saturation.
module tb_gene_timer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pause = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] gene_time = 32'd4;
  logic [7:0]  ovr8;
  logic [1:0]  ovr2;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  gene_timer_if gif ();
  gene_timer_if gif2 ();
  assign gif.gene_ack  = ack;
  assign gif2.gene_ack = ack;

  gene_timer #(.OVR_W(8), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_pause(pause),
    .i_gene_time(gene_time), .gif(gif), .o_overrun(ovr8)
  );

  gene_timer #(.OVR_W(2), .LFSR_SEED(8'hA5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_pause(pause),
    .i_gene_time(gene_time), .gif(gif2), .o_overrun(ovr2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until gene_req is seen high, bounded.
  task automatic run_until_req(output int cnt);
    cnt = 0;
    while (gif.gene_req !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  // Expected lane of the k-th request issued after reset.
  function automatic logic [31:0] exp_lane(input int k);
`ifdef GENE_LFSR_EN
    logic [7:0] s;
    s = 8'hA5;
    for (int j = 0; j <= k; j++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return 32'(s[1:0]);
`else
    return 32'(k % 4);
`endif
  endfunction

  task automatic do_reset();
    en = 1'b0; pause = 1'b0; ack = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset_check(input string tag);
    #1;
    rst_n = 1'b0;
    #2;
    check({tag, "_req"},  32'(gif.gene_req), 32'd0);
    check({tag, "_lane"}, 32'(gif.gene_lane), 32'd0);
    check({tag, "_ovr"},  32'(ovr8), 32'd0);
    check({tag, "_ovr2"}, 32'(ovr2), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    gene_time = 32'd4;
    do_reset();
    check("rst_req",  32'(gif.gene_req), 32'd0);
    check("rst_lane", 32'(gif.gene_lane), 32'd0);
    check("rst_ovr",  32'(ovr8), 32'd0);

    // P=4, prompt ack: first req after 5 edges, then every 5, lanes in sequence
    en = 1'b1;
    run_until_req(n);
    check("p4_first", 32'(n), 32'd5);
    check("p4_lane0", 32'(gif.gene_lane), exp_lane(0));
    for (int i = 1; i < 5; i++) begin
      ack = 1'b1;
      step();
      check("p4_ackdrop", 32'(gif.gene_req), 32'd0);
      ack = 1'b0;
      run_until_req(n);
      check("p4_interval", 32'(n + 1), 32'd5);
      check("p4_lane", 32'(gif.gene_lane), exp_lane(i));
    end
    check("p4_ovr", 32'(ovr8), 32'd0);

    // P=2, no ack for 20 edges: request held, 6 lost expiries, 2-bit saturates at 3
    gene_time = 32'd2;
    do_reset();
    en = 1'b1;
    run_until_req(n);
    check("p2_first", 32'(n), 32'd3);
    for (int i = 0; i < 20; i++) step();
    check("p2_req",  32'(gif.gene_req), 32'd1);
    check("p2_lane", 32'(gif.gene_lane), exp_lane(0));
    check("p2_ovr",  32'(ovr8), 32'd6);
    check("p2_ovr_sat", 32'(ovr2), 32'd3);
    async_reset_check("p2_arst");

    // Period change 9->3 mid-period: current period stays 10, then 4
    gene_time = 32'd9;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    gene_time = 32'd3;
    run_until_req(n);
    check("chg_first", 32'(n + 4), 32'd10);
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      run_until_req(n);
      check("chg_interval", 32'(n + 1), 32'd4);
    end

    // Pause 7 edges at cnt=2 with P=4: expiry delayed by exactly 7
    gene_time = 32'd4;
    do_reset();
    en = 1'b1;
    step();
    step();
    pause = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("pause_noreq", 32'(gif.gene_req), 32'd0);
    pause = 1'b0;
    run_until_req(n);
    check("pause_rest", 32'(n), 32'd3);
    pause = 1'b1;
    ack = 1'b1;
    step();
    check("pause_ack", 32'(gif.gene_req), 32'd0);
    ack = 1'b0;
    pause = 1'b0;
    check("pause_ovr", 32'(ovr8), 32'd0);

    // Expiry coincident with ack: req stays high, lane advances, no overrun
    gene_time = 32'd2;
    do_reset();
    en = 1'b1;
    run_until_req(n);
    check("coin_first", 32'(n), 32'd3);
    step();
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("coin_req",  32'(gif.gene_req), 32'd1);
    check("coin_lane", 32'(gif.gene_lane), exp_lane(1));
    check("coin_ovr",  32'(ovr8), 32'd0);
    async_reset_check("coin_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gene_timer.md
# gene_timer

Consumer end of the generation-period interface: takes the 32-bit `gene_time` period produced by the level controller and turns it into periodic block-generation requests for the spawner. It counts clock cycles against a latched copy of the period, picks a lane for each new block, and handshakes each request with the spawner using req/ack. It also keeps a saturating count of periods that expired while a request was still outstanding.

## Interface
- `OVR_W`, 8, width of the overrun counter.
- `LFSR_SEED`, 8'hA5, reset value of the lane LFSR. Must be non-zero.
- `clk` input 1: single system clock. All state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: game running. When low, the timer is held idle.
- `pause` input 1: freezes counting. Any outstanding request is kept.
- `gene_time` input 32: period value P. A tick occurs every P+1 cycles.
- `gene_req` output 1: a generation request is pending.
- `gene_lane` output 2: lane for the pending request. Valid and stable while `gene_req` is high.
- `gene_ack` input 1: spawner accepts the request. Only meaningful while `gene_req` is high.
- `overrun` output OVR_W: number of expiries lost because a request was still pending. Saturates at all-ones.

## Operation
- Internal state: `cnt[31:0]`, `period_q[31:0]`, `lane_src[7:0]`, and the `gene_req`, `gene_lane` and `overrun` registers.
- Idle (`en`=0):
  - `cnt`←0.
  - `period_q`←`gene_time`.
  - `gene_req`←0.
  - `overrun` and `lane_src` are held.
- Run (`en`=1, `pause`=0):
  - If `cnt`==`period_q`, this is an expiry. Then `cnt`←0, `period_q`←`gene_time`, and the expiry is handled by the handshake rules below.
  - Otherwise `cnt`←`cnt`+1.
- Pause (`en`=1, `pause`=1):
  - `cnt` and `period_q` are frozen and no expiry occurs.
  - The handshake still completes: an ack still clears `gene_req`.
- Period latching:
  - A `gene_time` change mid-period takes effect only at the next expiry or while idle. A period is never shortened or lengthened in flight.
  - P=0 gives an expiry every run cycle.
- Handshake (one request outstanding at most):
  - Expiry with `gene_req`=0: `gene_req`←1, `gene_lane`←next lane, lane source advances.
  - Expiry with `gene_req`=1 and `gene_ack`=0: request and lane unchanged; `overrun`←`overrun`+1, saturating.
  - Expiry with `gene_req`=1 and `gene_ack`=1: old request retires. A new request is issued on the same edge, so `gene_req` stays 1, `gene_lane` updates, and there is no overrun.
  - No expiry and `gene_req`=1 and `gene_ack`=1: `gene_req`←0.
  - `gene_ack` while `gene_req`=0: ignored.
- Lane selection: see Configuration. The lane source advances only when a request is issued.

## Timing
- Reset values:
  - `gene_req`=0, `gene_lane`=0, `overrun`=0.
  - `cnt`=0, `period_q`=32'h00030D3F, `lane_src`=`LFSR_SEED`.
- First expiry comes P+1 run cycles after `en` rises. `gene_req` is registered and goes high on that edge.
- The request drops on the edge where `gene_ack` is sampled high. Minimum request width is 1 cycle (ack in the same cycle as assertion is legal).
- Steady state with prompt ack: exactly one request per P+1 run cycles. Pause cycles do not count.
- Asserting reset mid-request clears everything immediately, without waiting for the clock.
- Counter wrap cannot occur: `cnt` never exceeds `period_q`.

## Configuration
- `GENE_LFSR_EN` defined:
  - `lane_src` is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - On each issue, the LFSR shifts once and `gene_lane` takes new `lane_src[1:0]`.
- `GENE_LFSR_EN` undefined:
  - `lane_src[1:0]` is a round-robin counter starting at 0.
  - On each issue, `gene_lane` takes the current value and the counter then increments. Lanes go 0,1,2,3,0,… and `LFSR_SEED` is unused.

## Test plan
- Reset, `en`=1, `gene_time`=4, ack 1 cycle after each req → req rises at cycle 5 then every 5 cycles; `overrun` stays 0.
- `gene_time`=2, `gene_ack` held 0 for 20 cycles → `gene_req` stays 1 with stable lane; `overrun`=6 (saturation checked with `OVR_W`=2 → 3).
- Change `gene_time` 9→3 mid-period → current period still ends at 10 cycles, following periods are 4 cycles.
- `pause` high for 7 cycles at `cnt`=2, P=4 → expiry delayed exactly 7 cycles; a pending ack during pause still clears `gene_req`.
- Expiry coincident with ack → `gene_req` stays 1 across the edge, `gene_lane` advances, `overrun` unchanged.
- Without `GENE_LFSR_EN`, 5 prompt-acked requests → lanes 0,1,2,3,0. With the macro, lanes match a reference LFSR model from seed 8'hA5. Pulsing `rst_n` low mid-request clears all outputs to their reset values immediately.
